// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-memory load path: loader FSM states and
// the default instruction-memory depth used by the loader and the imem write port.
package cpu_pkg;

   localparam int DEPTH_DEFAULT = 64;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      COUNT = 3'd1,
      DATA  = 3'd2,
      WRITE = 3'd3,
      FIN   = 3'd4
   } load_state_e;

endpackage

// File: rtl/byte_packer.sv
// Four-byte little-endian word assembler: each accepted byte lands in the lane
// selected by a 2-bit index that wraps 3 -> 0.
module byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_full_o
);

   logic [31:0] word_q;
   logic [1:0]  idx_q;

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         word_q <= '0;
         idx_q  <= '0;
      end else if (en_i) begin
         word_q[{idx_q, 3'b000} +: 8] <= byte_i;
         idx_q                        <= idx_q + 2'd1;
      end
   end

   // High in the cycle whose accepted byte completes the word.
   assign word_full_o = en_i && (idx_q == 2'd3);
   assign word_o      = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: takes a word count N then N little-endian 32-bit words from a byte
// stream and writes them to instruction memory from address 0, holding the core in reset.
module imem_loader
   import cpu_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [6:0]    words_loaded
);

   localparam int WIW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   load_state_e    state_q;
   logic [7:0]     n_q;
   logic [WIW-1:0] word_idx_q;
   logic [6:0]     words_q;
   logic           mem_we_q;
   logic [AW-1:0]  mem_addr_q;
   logic           done_q;
   logic           error_q;

   logic        accept;
   logic        pk_en;
   logic        pk_clr;
   logic        pk_full;
   logic [31:0] pk_word;
   logic [6:0]  next_words;

   // Stream handshake: a byte transfers on a rising edge where in_valid and in_ready
   // are both high; the producer holds in_data stable until then, so bytes stall, never drop.
   assign in_ready   = (state_q == COUNT) || (state_q == DATA);
   assign busy       = (state_q == COUNT) || (state_q == DATA) || (state_q == WRITE);
   assign accept     = in_valid && in_ready;
   assign pk_en      = accept && (state_q == DATA);
   assign pk_clr     = start && ((state_q == IDLE) || (state_q == FIN));
   assign next_words = words_q + 7'd1;

   byte_packer u_packer (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (pk_clr),
      .en_i        (pk_en),
      .byte_i      (in_data),
      .word_o      (pk_word),
      .word_full_o (pk_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         n_q        <= '0;
         word_idx_q <= '0;
         words_q    <= '0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         case (state_q)
            IDLE, FIN: begin
               if (start) begin
                  state_q    <= COUNT;
                  done_q     <= 1'b0;
                  error_q    <= 1'b0;
                  words_q    <= '0;
                  word_idx_q <= '0;
                  mem_addr_q <= '0;
               end
            end
            COUNT: begin
               if (accept) begin
                  n_q <= in_data;
                  if ((in_data == 8'd0) || (int'(in_data) > DEPTH)) begin
                     state_q <= FIN;
                     error_q <= 1'b1;
                  end else begin
                     state_q <= DATA;
                  end
               end
            end
            DATA: begin
               if (pk_full) begin
                  state_q    <= WRITE;
                  mem_we_q   <= 1'b1;
                  mem_addr_q <= AW'({word_idx_q, 2'b00});
               end
            end
            WRITE: begin
               words_q    <= next_words;
               word_idx_q <= word_idx_q + WIW'(1);
               if ({1'b0, next_words} < n_q) begin
                  state_q <= DATA;
               end else begin
                  state_q <= FIN;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // The packer register already holds the complete word throughout WRITE.
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = pk_word;
   assign done         = done_q;
   assign error        = error_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load sessions plus hand-written sequences for
// mid-word reset, start while busy and reset/start collision.
module tb_imem_loader;

   localparam int DEPTH = 64;
   localparam int AW    = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          busy;
   logic          done;
   logic          error;
   logic [6:0]    words_loaded;

   always #5 clk = ~clk;

   imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   typedef struct {
      logic [7:0]  n_byte;
      int          nwords;
      logic [31:0] w0;
      logic [31:0] w1;
      logic        gap;
      logic        exp_done;
      logic        exp_err;
      logic [6:0]  exp_words;
   } vec_t;

   vec_t        vecs[7];
   logic [63:0] exp_q[$];
   int          n_vec = 0;
   int          n_bad = 0;

   function automatic logic [31:0] word_of(input vec_t v, input int k);
      if (k == 0) return v.w0;
      if (k == 1) return v.w1;
      return {8'(k), 8'(255 - k), 8'hC3, 8'(k * 7)};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Every wait goes through here so each WRITE cycle is scored against exp_q.
   task automatic tick();
      logic [63:0] e;
      @(negedge clk);
      if (mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            check("write_addr_data", {mem_addr, mem_wdata}, e);
         end
         check("ready_low_in_write", {63'd0, in_ready}, 64'd0);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && t < 64) begin
         tick();
         t++;
      end
      if (!in_ready) begin
         n_vec++;
         n_bad++;
         $display("FAIL send_timeout: got in_ready=0 for 64 cycles, expected 1");
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 600) begin
         tick();
         t++;
      end
      if (busy) begin
         n_vec++;
         n_bad++;
         $display("FAIL idle_timeout: got busy=1 after 600 cycles, expected 0");
      end
   endtask

   task automatic send_word(input logic [31:0] w, input logic gap);
      for (int b = 0; b < 4; b++) begin
         if (gap) tick();
         send_byte(w[b*8 +: 8]);
      end
   endtask

   task automatic run_session(input vec_t v);
      logic [31:0] w;
      pulse_start();
      send_byte(v.n_byte);
      for (int k = 0; k < v.nwords; k++) begin
         w = word_of(v, k);
         exp_q.push_back({32'(k * 4), w});
         send_word(w, v.gap);
      end
      wait_idle();
      tick();
      check("done", {63'd0, done}, {63'd0, v.exp_done});
      check("error", {63'd0, error}, {63'd0, v.exp_err});
      check("words_loaded", {57'd0, words_loaded}, {57'd0, v.exp_words});
      check("ready_in_fin", {63'd0, in_ready}, 64'd0);
      check("writes_outstanding", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
      check({tag, "_mem_we"}, {63'd0, mem_we}, 64'd0);
      check({tag, "_mem_addr"}, {32'd0, mem_addr}, 64'd0);
      check({tag, "_mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
      check({tag, "_busy"}, {63'd0, busy}, 64'd0);
      check({tag, "_done"}, {63'd0, done}, 64'd0);
      check({tag, "_error"}, {63'd0, error}, 64'd0);
      check({tag, "_words_loaded"}, {57'd0, words_loaded}, 64'd0);
   endtask

   initial begin
      vecs[0] = '{8'h02, 2,  32'h00500013, 32'h00A00093, 1'b0, 1'b1, 1'b0, 7'd2};
      vecs[1] = '{8'h02, 2,  32'h00500013, 32'h00A00093, 1'b1, 1'b1, 1'b0, 7'd2};
      vecs[2] = '{8'h00, 0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 7'd0};
      vecs[3] = '{8'h41, 0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 7'd0};
      vecs[4] = '{8'h40, 64, 32'hDEADBEEF, 32'h12345678, 1'b0, 1'b1, 1'b0, 7'd64};
      vecs[5] = '{8'h03, 3,  32'hCAFEF00D, 32'h0BADC0DE, 1'b1, 1'b1, 1'b0, 7'd3};
      vecs[6] = '{8'h01, 1,  32'h80000001, 32'h0,        1'b0, 1'b1, 1'b0, 7'd1};

      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      for (int i = 0; i < 7; i++) begin
         run_session(vecs[i]);
      end

      // Reset after two data bytes of word 1: partial word dropped, next session from addr 0.
      pulse_start();
      send_byte(8'h02);
      send_byte(8'h13);
      send_byte(8'h00);
      rst = 1'b1;
      tick();
      check_reset_outputs("midword_rst");
      rst = 1'b0;
      tick();
      run_session(vecs[0]);

      // start asserted in WRITE and in DATA is ignored; the session completes unchanged.
      pulse_start();
      send_byte(8'h02);
      exp_q.push_back({32'h0, 32'h00500013});
      send_word(32'h00500013, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_start_words", {57'd0, words_loaded}, 64'd1);
      check("busy_start_busy", {63'd0, busy}, 64'd1);
      exp_q.push_back({32'h4, 32'h00A00093});
      start = 1'b1;
      send_byte(8'h93);
      start = 1'b0;
      send_byte(8'h00);
      send_byte(8'hA0);
      send_byte(8'h00);
      wait_idle();
      tick();
      check("busy_start_done", {63'd0, done}, 64'd1);
      check("busy_start_total", {57'd0, words_loaded}, 64'd2);
      check("busy_start_outstanding", 64'(exp_q.size()), 64'd0);

      // rst and start together from FIN: reset wins, no session begins.
      rst   = 1'b1;
      start = 1'b1;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      check("rst_prio_busy", {63'd0, busy}, 64'd0);
      check("rst_prio_done", {63'd0, done}, 64'd0);
      tick();
      check("rst_prio_still_idle", {63'd0, busy}, 64'd0);
      check("rst_prio_ready", {63'd0, in_ready}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
